// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO sequencer for the EX stage: iterative shift-add multiply and restoring divide,
// plus direct MTHI/MTLO writes, with busy held for the full operation.
module muldiv_hilo_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_FIX   = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   acc_hi_q, acc_lo_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [WIDTH-1:0]   a_raw_q;
   logic               is_div_q, neg_res_q, neg_rem_q, b_zero_q;
   logic               busy_q, done_q, dbz_q;
   logic [WIDTH-1:0]   hi_q, lo_q;

   logic               accept_s;
   logic [WIDTH-1:0]   a_mag_s, b_mag_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH:0]     div_shift_s, div_diff_s;
   logic               div_ge_s;
   logic [2*WIDTH-1:0] prod_neg_s;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
      if (is_signed && v[WIDTH-1]) begin
         return -v;
      end else begin
         return v;
      end
   endfunction

   // Operand conditioning and one-iteration datapath
   always_comb begin
      accept_s    = (state_q == S_IDLE) && !flush && start && !op[2];
      a_mag_s     = magnitude(src_a, op[0]);
      b_mag_s     = magnitude(src_b, op[0]);
      mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_diff_s  = div_shift_s - {1'b0, opnd_q};
      div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
      prod_neg_s  = -{acc_hi_q, acc_lo_q};
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept_s) state_d = S_CALC; else state_d = S_IDLE;
         S_CALC: begin
            if (flush)                           state_d = S_IDLE;
            else if (cnt_q == CNT_W'(1))         state_d = S_FIX;
            else                                 state_d = S_CALC;
         end
         S_FIX:   if (flush) state_d = S_IDLE; else state_d = S_WRITE;
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register and registered status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_WRITE);
         dbz_q   <= (state_d == S_WRITE) && is_div_q && b_zero_q;
      end
   end

   // Iteration datapath and architectural HI/LO
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= {CNT_W{1'b0}};
         acc_hi_q  <= {WIDTH{1'b0}};
         acc_lo_q  <= {WIDTH{1'b0}};
         opnd_q    <= {WIDTH{1'b0}};
         a_raw_q   <= {WIDTH{1'b0}};
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         b_zero_q  <= 1'b0;
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_s) begin
                  cnt_q     <= CNT_W'(WIDTH);
                  is_div_q  <= op[1];
                  neg_res_q <= op[0] && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  neg_rem_q <= op[0] && src_a[WIDTH-1];
                  b_zero_q  <= (src_b == {WIDTH{1'b0}});
                  a_raw_q   <= src_a;
                  acc_hi_q  <= {WIDTH{1'b0}};
                  // Multiply shifts the multiplier out of LO; divide shifts the dividend out of LO
                  acc_lo_q  <= op[1] ? a_mag_s : b_mag_s;
                  opnd_q    <= op[1] ? b_mag_s : a_mag_s;
               end else if (!flush && start && (op == OP_MTHI)) begin
                  hi_q <= src_a;
               end else if (!flush && start && (op == OP_MTLO)) begin
                  lo_q <= src_a;
               end
            end
            S_CALC: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (is_div_q) begin
                  acc_hi_q <= div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
                  acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge_s};
               end else begin
                  {acc_hi_q, acc_lo_q} <= {mul_sum_s, acc_lo_q[WIDTH-1:1]};
               end
            end
            S_FIX: begin
               if (is_div_q) begin
                  if (b_zero_q) begin
                     acc_lo_q <= {WIDTH{1'b1}};
                     acc_hi_q <= a_raw_q;
                  end else begin
                     if (neg_res_q) acc_lo_q <= -acc_lo_q;
                     if (neg_rem_q) acc_hi_q <= -acc_hi_q;
                  end
               end else if (neg_res_q) begin
                  {acc_hi_q, acc_lo_q} <= prod_neg_s;
               end
            end
            S_WRITE: begin
               hi_q <= acc_hi_q;
               lo_q <= acc_lo_q;
            end
            default: begin
               cnt_q <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi_out      = hi_q;
   assign lo_out      = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed self-checking bench for muldiv_hilo_ctrl with hand-computed HI/LO results.
module tb_muldiv_hilo_ctrl;

   localparam logic [2:0] MULTU = 3'b000, MULT = 3'b001, DIVU = 3'b010, DIV = 3'b011;
   localparam logic [2:0] MTHI  = 3'b100, MTLO = 3'b101, RSVD = 3'b110;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] src_a = 32'h0, src_b = 32'h0;
   logic        flush = 1'b0;
   logic        busy, done, div_by_zero;
   logic [31:0] hi_out, lo_out;

   int checks_q = 0;
   int failures_q = 0;

   muldiv_hilo_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_q++;
      if (got !== exp) begin
         failures_q++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One-cycle request; returns at the falling edge right after the accepting rising edge
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int n, output logic dbz);
      n = 0;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      dbz = div_by_zero;
      if (!done) check_val("done_timeout", 64'd0, 64'd1);
      @(negedge clk);
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dbz);
      int n;
      logic dbz;
      issue(o, a, b);
      wait_done(n, dbz);
      check_val({tag, "_dbz"}, {63'd0, dbz}, {63'd0, exp_dbz});
      check_val({tag, "_hilo"}, {hi_out, lo_out}, {exp_hi, exp_lo});
   endtask

   initial begin
      int n;
      logic dbz;
      #12;
      check_val("rst_busy", {63'd0, busy}, 64'd0);
      check_val("rst_done", {63'd0, done}, 64'd0);
      check_val("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
      check_val("rst_hilo", {hi_out, lo_out}, 64'd0);
      @(negedge clk);
      reset = 1'b1;

      issue(MTHI, 32'h0000_A5A5, 32'h0);
      check_val("mthi", {32'd0, hi_out}, {32'd0, 32'h0000_A5A5});
      check_val("mthi_busy", {63'd0, busy}, 64'd0);
      issue(MTLO, 32'h0000_5A5A, 32'h0);
      check_val("mtlo", {hi_out, lo_out}, {32'h0000_A5A5, 32'h0000_5A5A});

      issue(RSVD, 32'hDEAD_BEEF, 32'h1);
      check_val("rsvd_busy", {63'd0, busy}, 64'd0);
      check_val("rsvd_hilo", {hi_out, lo_out}, {32'h0000_A5A5, 32'h0000_5A5A});

      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = MTHI; src_a = 32'hDEAD_0000;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check_val("idle_flush_prio", {32'd0, hi_out}, {32'd0, 32'h0000_A5A5});

      // Full-latency multiply with HI/LO checked one cycle after done
      issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check_val("multu_busy", {63'd0, busy}, 64'd1);
      check_val("multu_hilo_hold", {hi_out, lo_out}, {32'h0000_A5A5, 32'h0000_5A5A});
      wait_done(n, dbz);
      check_val("multu_latency", 64'(n), 64'd33);
      check_val("multu_hilo", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
      check_val("multu_busy_fall", {63'd0, busy}, 64'd0);

      run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_op("div_neg",  DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("divu_zero", DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
      run_op("div_ovf",  DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
      run_op("divu_plain", DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0);

      issue(MULTU, 32'd6, 32'd7);
      issue(MTHI, 32'h0000_1234, 32'h0);
      wait_done(n, dbz);
      check_val("mthi_busy_ignored", {hi_out, lo_out}, {32'h0, 32'h0000_002A});

      issue(DIVU, 32'd9, 32'd4);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_val("flush_busy", {63'd0, busy}, 64'd0);
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) n++;
      end
      check_val("flush_no_done", 64'(n), 64'd0);
      check_val("flush_hilo", {hi_out, lo_out}, {32'h0, 32'h0000_002A});

      issue(MTHI, 32'h0000_0077, 32'h0);
      issue(MULTU, 32'd5, 32'd5);
      repeat (5) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_val("rst_mid_busy", {63'd0, busy}, 64'd0);
      check_val("rst_mid_hilo", {hi_out, lo_out}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      issue(MTLO, 32'h0000_0005, 32'h0);
      check_val("post_rst_mtlo", {hi_out, lo_out}, {32'h0, 32'h0000_0005});

      $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
      $finish;
   end

endmodule
